// File: rtl/cva6_icache_pkg.sv
// Shared types and default sizing for the icache data-array controller.
package cva6_icache_pkg;

    localparam int unsigned DefNumWords    = 256;
    localparam int unsigned DefDataWidth   = 128;
    localparam int unsigned DefWayCount    = 4;
    localparam int unsigned DefStarveLimit = 4;

    typedef enum logic [1:0] {
        StInit,
        StRun,
        StFlush
    } state_e;

    typedef enum logic [1:0] {
        GntNone,
        GntRd,
        GntWr
    } gnt_sel_e;

endpackage

// File: rtl/cva6_icache_data_prio.sv
// Two-requester arbiter: refill writes win contention until reads have been
// passed over StarveLimit times in a row.
module cva6_icache_data_prio
    import cva6_icache_pkg::*;
#(
    parameter int unsigned StarveLimit = DefStarveLimit
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic rd_req_i,
    input  logic wr_req_i,
    output logic rd_gnt_o,
    output logic wr_gnt_o
);

    localparam int unsigned CntWidth = $clog2(StarveLimit + 1);

    logic [CntWidth-1:0] r_starve;
    logic [CntWidth-1:0] w_starve_d;
    logic                w_starved;
    gnt_sel_e            w_sel;

    assign w_starved = (r_starve == CntWidth'(StarveLimit));

    always_comb begin
        w_sel = GntNone;
        if (en_i) begin
            if (rd_req_i && wr_req_i) begin
                w_sel = w_starved ? GntRd : GntWr;
            end else if (rd_req_i) begin
                w_sel = GntRd;
            end else if (wr_req_i) begin
                w_sel = GntWr;
            end
        end
    end

    // A write grant with rd_req_i high is always contended and never starved.
    always_comb begin
        w_starve_d = r_starve;
        if (!rd_req_i || (w_sel == GntRd)) begin
            w_starve_d = '0;
        end else if (w_sel == GntWr) begin
            w_starve_d = r_starve + CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_starve <= '0;
        end else begin
            r_starve <= w_starve_d;
        end
    end

    assign rd_gnt_o = (w_sel == GntRd);
    assign wr_gnt_o = (w_sel == GntWr);

endmodule

// File: rtl/cva6_icache_data_ctrl.sv
// Icache data-SRAM sequencer: zero-fill sweep after reset/flush, then
// arbitrates the shared SRAM port between fetch reads and refill writes.
module cva6_icache_data_ctrl
    import cva6_icache_pkg::*;
#(
    parameter int unsigned NumWords    = DefNumWords,
    parameter int unsigned DataWidth   = DefDataWidth,
    parameter int unsigned WayCount    = DefWayCount,
    parameter int unsigned StarveLimit = DefStarveLimit,
    parameter int unsigned AddrWidth   = $clog2(NumWords)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    output logic                          busy_o,
    input  logic                          rd_req_i,
    output logic                          rd_gnt_o,
    input  logic [AddrWidth-1:0]          rd_addr_i,
    input  logic [WayCount-1:0]           rd_way_i,
    output logic                          rd_rvalid_o,
    output logic [WayCount*DataWidth-1:0] rd_rdata_o,
    input  logic                          wr_req_i,
    output logic                          wr_gnt_o,
    input  logic [AddrWidth-1:0]          wr_addr_i,
    input  logic [WayCount-1:0]           wr_way_i,
    input  logic [DataWidth-1:0]          wr_data_i,
    input  logic [DataWidth/8-1:0]        wr_be_i,
    output logic [WayCount-1:0]           sram_req_o,
    output logic                          sram_we_o,
    output logic [AddrWidth-1:0]          sram_addr_o,
    output logic [DataWidth-1:0]          sram_wdata_o,
    output logic [DataWidth/8-1:0]        sram_be_o,
    input  logic [WayCount*DataWidth-1:0] sram_rdata_i
);

    state_e               r_state;
    state_e               w_state_d;
    logic [AddrWidth-1:0] r_cnt;
    logic [AddrWidth-1:0] w_cnt_d;
    logic                 r_rvalid;
    logic                 w_run_en;
    logic                 w_rd_gnt;
    logic                 w_wr_gnt;

    assign w_run_en = (r_state == StRun) && !flush_i;

    cva6_icache_data_prio #(
        .StarveLimit(StarveLimit)
    ) u_prio (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (w_run_en),
        .rd_req_i(rd_req_i),
        .wr_req_i(wr_req_i),
        .rd_gnt_o(w_rd_gnt),
        .wr_gnt_o(w_wr_gnt)
    );

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        unique case (r_state)
            StInit, StFlush: begin
                if (flush_i) begin
                    w_state_d = StFlush;
                    w_cnt_d   = '0;
                end else if (r_cnt == AddrWidth'(NumWords - 1)) begin
                    w_state_d = StRun;
                end else begin
                    w_cnt_d = r_cnt + AddrWidth'(1);
                end
            end
            StRun: begin
                if (flush_i) begin
                    w_state_d = StFlush;
                    w_cnt_d   = '0;
                end
            end
            default: begin
                w_state_d = StInit;
                w_cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        sram_req_o   = '0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_be_o    = '0;
        if (r_state != StRun) begin
            sram_req_o  = '1;
            sram_we_o   = 1'b1;
            sram_addr_o = r_cnt;
            sram_be_o   = '1;
        end else if (w_rd_gnt) begin
            sram_req_o  = rd_way_i;
            sram_addr_o = rd_addr_i;
        end else if (w_wr_gnt) begin
            sram_req_o   = wr_way_i;
            sram_we_o    = 1'b1;
            sram_addr_o  = wr_addr_i;
            sram_wdata_o = wr_data_i;
            sram_be_o    = wr_be_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= StInit;
            r_cnt    <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_cnt    <= w_cnt_d;
            r_rvalid <= w_rd_gnt;
        end
    end

    assign busy_o      = (r_state != StRun);
    assign rd_gnt_o    = w_rd_gnt;
    assign wr_gnt_o    = w_wr_gnt;
    assign rd_rvalid_o = r_rvalid;
    assign rd_rdata_o  = sram_rdata_i;

endmodule

// File: doc/cva6_icache_data_ctrl.md
Name: cva6_icache_data_ctrl

Overview:
- Sequencer and arbiter in front of the instruction-cache data SRAM array, one macro per way, sharing one address/data bus.
- Shares the single SRAM port between the fetch read path and the refill write path, using a starvation-bounded priority scheme.
- Runs a zero-fill sweep of every way after reset and on flush.
- Sits between the icache controller and the data SRAM wrapper; owns the SRAM request/enable sequencing.

Parameters:
- NumWords, 256: words per way; any value ≥2, power of two not required.
- DataWidth, 128: SRAM word width.
- WayCount, 4: number of ways / SRAM macros.
- StarveLimit, 4: maximum consecutive contended refill grants before a read is forced through; must be ≥1.
- AddrWidth, $clog2(NumWords): derived, do not override.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- flush_i  in  1  start zero-fill sweep (single-cycle pulse or level)
- busy_o  out  1  sweep in progress; all requests refused
- rd_req_i  in  1  fetch read request
- rd_gnt_o  out  1  read accepted this cycle
- rd_addr_i  in  AddrWidth  read word index
- rd_way_i  in  WayCount  ways to enable for the read (one-hot or all)
- rd_rvalid_o  out  1  read data valid, one cycle after grant
- rd_rdata_o  out  WayCount*DataWidth  read data, way i at [i*DataWidth +: DataWidth]
- wr_req_i  in  1  refill write request
- wr_gnt_o  out  1  write accepted this cycle
- wr_addr_i  in  AddrWidth  write word index
- wr_way_i  in  WayCount  target way(s)
- wr_data_i  in  DataWidth  write data
- wr_be_i  in  DataWidth/8  byte enables
- sram_req_o  out  WayCount  per-way SRAM request
- sram_we_o  out  1  SRAM write enable
- sram_addr_o  out  AddrWidth  SRAM address
- sram_wdata_o  out  DataWidth  SRAM write data
- sram_be_o  out  DataWidth/8  SRAM byte enables
- sram_rdata_i  in  WayCount*DataWidth  SRAM read data, 1-cycle latency

Behaviour:
- One clock domain. rst_i is asynchronous and active-high; it forces every register to its reset value immediately.
- Reset values:
  - state = INIT, sweep counter = 0, starve counter = 0, rd_rvalid_o = 0.
  - busy_o = 1, rd_gnt_o = 0, wr_gnt_o = 0.
  - SRAM outputs show the INIT word-0 write (harmless, because the SRAMs are also in reset).
- States:
  - INIT and FLUSH: sweep. Each cycle: sram_req_o = all ones, sram_we_o = 1, sram_addr_o = counter, sram_wdata_o = 0, sram_be_o = all ones. Counter increments each cycle. After writing NumWords-1, go to RUN; no wrap.
  - RUN: arbitration.
- Sweep timing: the sweep takes exactly NumWords cycles. busy_o = (state != RUN) and is registered-state based.
- flush_i handling:
  - During INIT or FLUSH: counter restarts at 0, state becomes FLUSH.
  - During RUN: both grants forced to 0 that cycle; FLUSH with counter 0 next cycle.
  - A read granted in the preceding cycle still gets its rd_rvalid_o.
- RUN arbitration (combinational grants, same cycle as request):
  - Only rd_req_i: rd_gnt_o = 1.
  - Only wr_req_i: wr_gnt_o = 1.
  - Both: write wins unless starve counter == StarveLimit; then read wins.
  - Starve counter increments on every contended write grant, saturating at StarveLimit. It clears on any read grant or any cycle with rd_req_i = 0.
- SRAM drive on read grant: sram_req_o = rd_way_i, we = 0, addr = rd_addr_i.
- SRAM drive on write grant: sram_req_o = wr_way_i, we = 1, addr/data/be taken from the wr_* ports.
- No grant: sram_req_o = 0.
- Read return: rd_rvalid_o is a register set to rd_gnt_o. rd_rdata_o = sram_rdata_i passed through; it is meaningful only while rd_rvalid_o = 1.
- Request hold: requesters keep req and payload stable until granted; the block does not buffer payloads.
- Starve counter width: $clog2(StarveLimit+1).

Decomposition:
- Shared package cva6_icache_pkg holds:
  - the state enum (INIT, RUN, FLUSH);
  - a grant-select enum (NONE, RD, WR);
  - the default-parameter constants.
- One sub-module: cva6_icache_data_prio, containing the two-requester starvation-bounded priority arbiter and its starve counter.

Test Plan (NumWords=256, WayCount=4, StarveLimit=4):
- Release reset -> for 256 cycles: sram_req_o = 4'b1111, we = 1, addr 0..255, wdata = 0, all grants 0. busy_o drops in cycle 256.
- RUN, rd_req_i with addr 0x12, way 4'b0010 -> same cycle rd_gnt_o = 1, sram_req_o = 4'b0010, we = 0, addr 0x12. Next cycle rd_rvalid_o = 1 and rd_rdata_o[255:128] = sram data.
- rd_req_i and wr_req_i both held for 10 cycles -> grant sequence W,W,W,W,R,W,W,W,W,R; rvalid follows each R by exactly one cycle.
- Read granted in cycle N, then flush_i plus rd_req_i in cycle N+1 -> no grants in N+1, rd_rvalid_o = 1 in N+1. Sweep writes addr 0 in N+2 and busy_o stays high 256 cycles.
- flush_i while INIT counter = 100 -> counter restarts at 0. busy_o stays high a further 256 cycles, total 357 cycles from reset release.
- rst_i asserted mid-FLUSH (counter = 50) -> immediately state = INIT, counter = 0, rd_rvalid_o = 0. Full 256-cycle sweep after release.
